// File: rtl/ram_pkg.sv
// Shared definitions for the single-port RAM with clear sequencer.
// State encoding and default geometry.
package ram_pkg;

    localparam int RAM_DATA_W_DEF = 8;
    localparam int RAM_ADDR_W_DEF = 4;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } ram_state_e;

endpackage

// File: rtl/ram_init_ctrl.sv
// Clear sequencer: walks every address once, writing zero, then idles in READY.
// Leaves reset in CLEAR so the array is zeroed before first use.
module ram_init_ctrl
    import ram_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    output logic              busy,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              clr_we
);

    ram_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy     = 1'b0;
        clr_we   = 1'b0;
        clr_addr = cnt_q;
        unique case (state_q)
            ST_CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                if (cnt_q == '1) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            ST_READY: begin
                // clr inside CLEAR is ignored simply by not being looked at there
                if (clr) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/ram_sp_param.sv
// Single-port byte-writable RAM with self-clearing sequencer.
// Define RAM_SP_OUT_REG_EN to add an output register (read latency 2).
module ram_sp_param
    import ram_pkg::*;
#(
    parameter int DATA_W = RAM_DATA_W_DEF,
    parameter int ADDR_W = RAM_ADDR_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   din,
    input  logic                clr,
    output logic [DATA_W-1:0]   dout,
    output logic                dout_valid,
    output logic                busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              acc;
    logic              clr_hit;

    ram_init_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_init (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .busy     (busy),
        .clr_addr (clr_addr),
        .clr_we   (clr_we)
    );

    // clr wins over a same-cycle access
    assign clr_hit = clr & ~busy;
    assign acc     = en & ~busy & ~clr;

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (acc && we) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= din[8*i +: 8];
                end
            end
        end
    end

    logic [DATA_W-1:0] rdat_q, rdat_d;
    logic              rvld_q, rvld_d;

    always_comb begin
        rvld_d = acc & ~we;
        rdat_d = rdat_q;
        if (rvld_d) begin
            rdat_d = mem[addr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdat_q <= '0;
            rvld_q <= 1'b0;
        end else begin
            rdat_q <= rdat_d;
            rvld_q <= rvld_d;
        end
    end

`ifdef RAM_SP_OUT_REG_EN
    logic [DATA_W-1:0] odat_q, odat_d;
    logic              ovld_q, ovld_d;

    always_comb begin
        ovld_d = rvld_q & ~clr_hit;
        odat_d = odat_q;
        if (ovld_d) begin
            odat_d = rdat_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            odat_q <= '0;
            ovld_q <= 1'b0;
        end else begin
            odat_q <= odat_d;
            ovld_q <= ovld_d;
        end
    end

    assign dout       = odat_q;
    assign dout_valid = ovld_q;
`else
    logic unused_clr_hit;
    assign unused_clr_hit = clr_hit;
    assign dout           = rdat_q;
    assign dout_valid     = rvld_q;
`endif

endmodule

// File: tb/tb_ram_sp_param.sv
// Directed self-checking bench for ram_sp_param (DATA_W=16, ADDR_W=4).
// Follows RAM_SP_OUT_REG_EN for the expected read latency.
module tb_ram_sp_param;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
`ifdef RAM_SP_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk;
    logic          reset;
    logic          en;
    logic          we;
    logic [1:0]    be;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          clr;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          busy;

    int n_cmp;
    int n_bad;

    ram_sp_param #(
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .we         (we),
        .be         (be),
        .addr       (addr),
        .din        (din),
        .clr        (clr),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr_op(input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [1:0] b);
        en = 1'b1; we = 1'b1; addr = a; din = d; be = b;
        tick();
        en = 1'b0; we = 1'b0;
    endtask

    task automatic rd_op(input logic [AW-1:0] a, output logic [DW-1:0] d,
                         output logic v, output logic early);
        en = 1'b1; we = 1'b0; addr = a;
        early = 1'b0;
        tick();
        en = 1'b0;
        for (int k = 1; k < LAT; k++) begin
            if (dout_valid !== 1'b0) early = 1'b1;
            tick();
        end
        d = dout;
        v = dout_valid;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset;
        logic [DW-1:0] d;
        logic v, e;
        int n;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b1 || dout_valid !== 1'b0 || dout !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_out: busy=%b vld=%b dout=%h want 1 0 0000",
                     busy, dout_valid, dout);
        end
        tick(); tick();
        reset = 1'b0;
        count_busy(n);
        n_cmp++;
        if (n !== DEPTH) begin
            n_bad++;
            $display("FAIL reset_busy_len: got %0d want %0d", n, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            rd_op(AW'(i), d, v, e);
            n_cmp++;
            if (v !== 1'b1 || e !== 1'b0 || d !== 16'h0000) begin
                n_bad++;
                $display("FAIL reset_zero[%0d]: vld=%b early=%b dout=%h want 1 0 0000",
                         i, v, e, d);
            end
        end
    endtask

    task automatic test_write_read;
        logic [DW-1:0] d;
        logic v, e;
        wr_op(4'd5, 16'h00AA, 2'b11);
        wr_op(4'd12, 16'h0055, 2'b11);
        rd_op(4'd5, d, v, e);
        n_cmp++;
        if (v !== 1'b1 || e !== 1'b0 || d !== 16'h00AA) begin
            n_bad++;
            $display("FAIL rd5: vld=%b early=%b dout=%h want 1 0 00aa", v, e, d);
        end
        rd_op(4'd12, d, v, e);
        n_cmp++;
        if (v !== 1'b1 || e !== 1'b0 || d !== 16'h0055) begin
            n_bad++;
            $display("FAIL rd12: vld=%b early=%b dout=%h want 1 0 0055", v, e, d);
        end
        tick();
        n_cmp++;
        if (dout_valid !== 1'b0 || dout !== 16'h0055) begin
            n_bad++;
            $display("FAIL hold: vld=%b dout=%h want 0 0055", dout_valid, dout);
        end
    endtask

    task automatic test_byte_en;
        logic [DW-1:0] d;
        logic v, e;
        wr_op(4'd3, 16'h1234, 2'b11);
        wr_op(4'd3, 16'hABCD, 2'b10);
        rd_op(4'd3, d, v, e);
        n_cmp++;
        if (v !== 1'b1 || d !== 16'hAB34) begin
            n_bad++;
            $display("FAIL be_hi: vld=%b dout=%h want 1 ab34", v, d);
        end
        wr_op(4'd3, 16'hFFFF, 2'b00);
        rd_op(4'd3, d, v, e);
        n_cmp++;
        if (v !== 1'b1 || d !== 16'hAB34) begin
            n_bad++;
            $display("FAIL be_none: vld=%b dout=%h want 1 ab34", v, d);
        end
        wr_op(4'd3, 16'h9956, 2'b01);
        rd_op(4'd3, d, v, e);
        n_cmp++;
        if (v !== 1'b1 || d !== 16'hAB56) begin
            n_bad++;
            $display("FAIL be_lo: vld=%b dout=%h want 1 ab56", v, d);
        end
    endtask

    task automatic test_back_to_back;
        en = 1'b1; we = 1'b0; addr = 4'd5;
        for (int k = 1; k <= LAT + 1; k++) begin
            tick();
            if (k == LAT) begin
                n_cmp++;
                if (dout_valid !== 1'b1 || dout !== 16'h00AA) begin
                    n_bad++;
                    $display("FAIL b2b_first: vld=%b dout=%h want 1 00aa",
                             dout_valid, dout);
                end
            end
            if (k == LAT + 1) begin
                n_cmp++;
                if (dout_valid !== 1'b1 || dout !== 16'h0055) begin
                    n_bad++;
                    $display("FAIL b2b_second: vld=%b dout=%h want 1 0055",
                             dout_valid, dout);
                end
            end
            if (k == 1) addr = 4'd12;
            else en = 1'b0;
        end
        tick();
    endtask

    task automatic test_busy_discard;
        logic [DW-1:0] d;
        logic v, e;
        int n;
        int bad_vld;
        wr_op(4'd7, 16'h7777, 2'b11);
        clr = 1'b1;
        tick();
        n = 0;
        bad_vld = 0;
        while (busy === 1'b1 && n < 40) begin
            en = 1'b1; we = n[0]; addr = 4'd7; din = 16'hFFFF; be = 2'b11;
            clr = (n == 5);
            tick();
            n++;
            if (dout_valid !== 1'b0) bad_vld++;
        end
        en = 1'b0; we = 1'b0; clr = 1'b0;
        n_cmp++;
        if (n !== DEPTH) begin
            n_bad++;
            $display("FAIL busy_len: got %0d want %0d", n, DEPTH);
        end
        n_cmp++;
        if (bad_vld !== 0) begin
            n_bad++;
            $display("FAIL busy_vld: valid seen %0d times want 0", bad_vld);
        end
        rd_op(4'd7, d, v, e);
        n_cmp++;
        if (v !== 1'b1 || d !== 16'h0000) begin
            n_bad++;
            $display("FAIL busy_wr7: vld=%b dout=%h want 1 0000", v, d);
        end
    endtask

    task automatic test_clr_read;
        logic [DW-1:0] d;
        logic v, e;
        int n;
        int bad_vld;
        wr_op(4'd5, 16'h00AA, 2'b11);
        clr = 1'b1; en = 1'b1; we = 1'b0; addr = 4'd5;
        tick();
        clr = 1'b0; en = 1'b0;
        n = 0;
        bad_vld = 0;
        while (busy === 1'b1 && n < 40) begin
            if (dout_valid !== 1'b0) bad_vld++;
            tick();
            n++;
        end
        if (dout_valid !== 1'b0) bad_vld++;
        n_cmp++;
        if (n !== DEPTH || bad_vld !== 0) begin
            n_bad++;
            $display("FAIL clr_read: busy=%0d want %0d, valid seen %0d want 0",
                     n, DEPTH, bad_vld);
        end
        rd_op(4'd5, d, v, e);
        n_cmp++;
        if (v !== 1'b1 || d !== 16'h0000) begin
            n_bad++;
            $display("FAIL clr_rd5: vld=%b dout=%h want 1 0000", v, d);
        end
    endtask

    task automatic test_reset_mid_clear;
        logic [DW-1:0] d;
        logic v, e;
        int n;
        wr_op(4'd12, 16'hBEEF, 2'b11);
        wr_op(4'd9, 16'h1111, 2'b11);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b1 || dout_valid !== 1'b0 || dout !== 16'h0000) begin
            n_bad++;
            $display("FAIL mid_reset_out: busy=%b vld=%b dout=%h want 1 0 0000",
                     busy, dout_valid, dout);
        end
        tick(); tick();
        reset = 1'b0;
        count_busy(n);
        n_cmp++;
        if (n !== DEPTH) begin
            n_bad++;
            $display("FAIL mid_reset_busy: got %0d want %0d", n, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            rd_op(AW'(i), d, v, e);
            n_cmp++;
            if (v !== 1'b1 || d !== 16'h0000) begin
                n_bad++;
                $display("FAIL mid_reset_zero[%0d]: vld=%b dout=%h want 1 0000",
                         i, v, d);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        en    = 1'b0;
        we    = 1'b0;
        be    = 2'b00;
        addr  = '0;
        din   = '0;
        clr   = 1'b0;
        test_reset();
        test_write_read();
        test_byte_en();
        test_back_to_back();
        test_busy_discard();
        test_clr_read();
        test_reset_mid_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_sp_param.md
RAM_SP_PARAM -- requirements
Module: ram_sp_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data width in bits; legal values are multiples of 8, minimum 8.
REQ-002 SHALL have parameter ADDR_W, default 4, address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have port clk  input  1  single clock; all logic is rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port en  input  1  access request; ignored while busy=1.
REQ-006 SHALL have port we  input  1  1 = write, 0 = read; qualified by en.
REQ-007 SHALL have port be  input  DATA_W/8  byte enables for writes; bit i covers din[8i+7:8i].
REQ-008 SHALL have port addr  input  ADDR_W  word address.
REQ-009 SHALL have port din  input  DATA_W  write data.
REQ-010 SHALL have port clr  input  1  single-cycle pulse requesting a full-memory clear.
REQ-011 SHALL have port dout  output  DATA_W  read data.
REQ-012 SHALL have port dout_valid  output  1  dout holds the result of an accepted read.
REQ-013 SHALL have port busy  output  1  clear sequence in progress.

Function
REQ-014 SHALL implement a two-state FSM: CLEAR and READY.
REQ-015 SHALL write zero to addresses 0..DEPTH-1 in CLEAR, one word per cycle, ascending, and hold busy=1 throughout.
REQ-016 SHALL go CLEAR -> READY on the cycle after address DEPTH-1 is written; busy falls with the transition; the clear takes exactly DEPTH cycles.
REQ-017 SHALL go READY -> CLEAR on a sampled clr=1, restarting the clear at address 0; clr during CLEAR SHALL be ignored.
REQ-018 SHALL write, when en=1, we=1 and READY are sampled, only the bytes of din whose be bit is 1; be=0 SHALL leave the word unchanged.
REQ-019 SHALL, on a read sampled in READY, present mem[addr] on dout with dout_valid=1 one cycle later (base latency 1).
REQ-020 SHALL give dout_valid=0 on any cycle with no read result due; dout SHALL hold its last value when dout_valid=0.
REQ-021 SHALL discard en during busy=1: no write occurs and no dout_valid is produced.
REQ-022 SHALL give READY priority to clr over a same-cycle en: the access is discarded and the clear starts.
REQ-023 SHALL address modulo DEPTH; no out-of-range addresses exist.

Reset
REQ-024 SHALL, on reset=1, immediately force state=CLEAR, clear counter=0, dout=0, dout_valid=0 and busy=1.
REQ-025 SHALL, on reset assertion mid-clear or mid-read, abandon the operation; after reset deasserts, a full DEPTH-cycle clear SHALL run from address 0.
REQ-026 SHALL NOT reset the memory array directly; zeroing occurs only through the clear sequence.

Configuration
REQ-027 SHALL, with macro RAM_SP_OUT_REG_EN defined, add one output register stage, giving read latency 2 with dout_valid delayed to match.
REQ-028 SHALL, without RAM_SP_OUT_REG_EN, keep read latency 1; all other behaviour SHALL be identical.
REQ-029 SHALL reset the extra pipeline stage per REQ-024 and flush it on clr.

Structure
REQ-030 SHALL place the FSM state encoding (CLEAR, READY) and the default widths in shared package ram_pkg.
REQ-031 SHALL implement the clear counter and FSM in sub-module ram_init_ctrl, which drives busy, the clear address and the clear write strobe.

Verification
REQ-032 Reset pulse, defaults -> busy=1 for exactly 16 cycles after reset deasserts; a subsequent read of every address returns 8'h00.
REQ-033 Write 8'hAA to address 5 and 8'h55 to address 12, then read 5 and 12 -> dout=8'hAA then 8'h55, each with dout_valid=1 one cycle after the request (two cycles with RAM_SP_OUT_REG_EN).
REQ-034 DATA_W=16: write 16'h1234 to address 3, then write 16'hABCD with be=2'b10 -> read returns 16'hAB34.
REQ-035 Write to address 7 while busy=1 -> read of address 7 after the clear returns 0; no dout_valid is produced during busy.
REQ-036 clr and read of address 5 in the same READY cycle -> no dout_valid, busy=1 for 16 cycles, then address 5 reads 8'h00.
REQ-037 Reset asserted at clear address 9 -> after deassertion busy=1 for a full 16 cycles and every address reads 0.
